// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, flag positions, response payload
// and the control legality check used by the requester arbiter.
package alu_pkg;

    localparam int unsigned ALU_W  = 32;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned FLAG_W = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_SLT = 3'b101;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Payload captured into a response slot (tag is carried separately).
    typedef struct packed {
        logic [ALU_W-1:0]  result;
        logic [FLAG_W-1:0] flags;
        logic              err;
    } alu_rsp_t;

    function automatic logic ctrl_legal(input logic [CTRL_W-1:0] ctrl);
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ALU_8.sv
// Shared 32-bit ALU: add/sub/and/or/slt with carry and overflow outputs.
// slt reports the raw sign of A-B without overflow correction.
module ALU_8
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0]  a,
    input  logic [ALU_W-1:0]  b,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [ALU_W-1:0]  result,
    output logic              zero,
    output logic              carry,
    output logic              overflow
);

    logic [ALU_W:0]   sum;
    logic [ALU_W-1:0] b_in;

    always_comb begin
        b_in     = ctrl[0] ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_in} + (ALU_W+1)'(ctrl[0]);
        carry    = sum[ALU_W] & ~ctrl[1];
        overflow = ~ctrl[1] & (a[ALU_W-1] ^ sum[ALU_W-1])
                 & ~(a[ALU_W-1] ^ b[ALU_W-1] ^ ctrl[0]);
        case (ctrl)
            ALU_ADD, ALU_SUB: result = sum[ALU_W-1:0];
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            ALU_SLT:          result = {(ALU_W-1)'(0), sum[ALU_W-1]};
            default:          result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU_8 between two requesters, with a
// single-entry registered response slot per requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [2:0]        r0_ctrl,
    input  logic [TAG_W-1:0]  r0_tag,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [DATA_W-1:0] r0_rsp_result,
    output logic [3:0]        r0_rsp_flags,
    output logic              r0_rsp_err,
    output logic [TAG_W-1:0]  r0_rsp_tag,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [2:0]        r1_ctrl,
    input  logic [TAG_W-1:0]  r1_tag,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] r1_rsp_result,
    output logic [3:0]        r1_rsp_flags,
    output logic              r1_rsp_err,
    output logic [TAG_W-1:0]  r1_rsp_tag
);

    localparam int unsigned NREQ = 2;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ-1:0]   slot_valid;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic              rr_ptr;

    logic [DATA_W-1:0] req_a    [NREQ];
    logic [DATA_W-1:0] req_b    [NREQ];
    logic [2:0]        req_ctrl [NREQ];
    logic [TAG_W-1:0]  req_tag  [NREQ];

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ctrl;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_ovf;
    logic              alu_zero_unused;
    logic              legal;

    alu_rsp_t          new_rsp;
    alu_rsp_t          slot_rsp [NREQ];
    logic [TAG_W-1:0]  slot_tag [NREQ];

    assign req_valid   = {r1_valid, r0_valid};
    assign rsp_ready   = {r1_rsp_ready, r0_rsp_ready};
    assign req_a[0]    = r0_a;
    assign req_a[1]    = r1_a;
    assign req_b[0]    = r0_b;
    assign req_b[1]    = r1_b;
    assign req_ctrl[0] = r0_ctrl;
    assign req_ctrl[1] = r1_ctrl;
    assign req_tag[0]  = r0_tag;
    assign req_tag[1]  = r1_tag;

    // A requester whose own slot is stuck never blocks the other one.
    always_comb begin
        elig  = req_valid & (~slot_valid | rsp_ready);
        grant = '0;
        if (!rst) begin
            grant = '0;
        end else if (&elig) begin
            grant[rr_ptr] = 1'b1;
        end else begin
            grant = elig;
        end
    end

    assign r0_ready = grant[0];
    assign r1_ready = grant[1];

    // Pointer moves to the loser only when both requesters contended.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if (&elig) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    always_comb begin
        alu_a    = grant[1] ? req_a[1]    : req_a[0];
        alu_b    = grant[1] ? req_b[1]    : req_b[0];
        alu_ctrl = grant[1] ? req_ctrl[1] : req_ctrl[0];
        alu_tag  = grant[1] ? req_tag[1]  : req_tag[0];
    end

    ALU_8 u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .ctrl     (alu_ctrl),
        .result   (alu_result),
        .zero     (alu_zero_unused),
        .carry    (alu_carry),
        .overflow (alu_ovf)
    );

    // Illegal ops return a zero result but keep the computed C/V flags.
    always_comb begin
        legal                  = ctrl_legal(alu_ctrl);
        new_rsp                = '0;
        new_rsp.result         = legal ? alu_result : '0;
        new_rsp.flags[FLAG_N]  = new_rsp.result[DATA_W-1];
        new_rsp.flags[FLAG_Z]  = (new_rsp.result == '0);
        new_rsp.flags[FLAG_C]  = alu_carry;
        new_rsp.flags[FLAG_V]  = alu_ovf;
        new_rsp.err            = ~legal;
    end

    // Per-requester response slot: load beats drain, so no bubble on overlap.
    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!rst) begin
                slot_valid[i] <= 1'b0;
                slot_rsp[i]   <= '0;
                slot_tag[i]   <= '0;
            end else if (grant[i]) begin
                slot_valid[i] <= 1'b1;
                slot_rsp[i]   <= new_rsp;
                slot_tag[i]   <= alu_tag;
            end else if (slot_valid[i] && rsp_ready[i]) begin
                slot_valid[i] <= 1'b0;
            end
        end
    end

    assign r0_rsp_valid  = slot_valid[0];
    assign r0_rsp_result = slot_rsp[0].result;
    assign r0_rsp_flags  = slot_rsp[0].flags;
    assign r0_rsp_err    = slot_rsp[0].err;
    assign r0_rsp_tag    = slot_tag[0];

    assign r1_rsp_valid  = slot_valid[1];
    assign r1_rsp_result = slot_rsp[1].result;
    assign r1_rsp_flags  = slot_rsp[1].flags;
    assign r1_rsp_err    = slot_rsp[1].err;
    assign r1_rsp_tag    = slot_tag[1];

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU_8 datapath between two requesters: requester 0 is the core execute path and requester 1 is the auxiliary/multi-cycle unit.
- Each requester issues an operation with a valid/ready handshake and tag, and gets back a registered result, flags and tag on its own response channel.
- Arbitration is round-robin and respects response backpressure.
- Sits between issue logic and the single shared ALU instance.

Parameters:
- DATA_W, 32, operand/result width (ALU_8 is fixed at 32; other values unsupported)
- TAG_W, 4, width of requester-supplied tag returned with the response

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- rN_valid  in  1  request valid, N in {0,1}
- rN_ready  out  1  request accepted this cycle when rN_valid & rN_ready
- rN_a  in  DATA_W  operand A
- rN_b  in  DATA_W  operand B
- rN_ctrl  in  3  ALU control: 000 add, 001 sub, 010 and, 011 or, 101 slt; 100/110/111 illegal
- rN_tag  in  TAG_W  opaque tag
- rN_rsp_valid  out  1  response slot full
- rN_rsp_ready  in  1  consumer takes response when rN_rsp_valid & rN_rsp_ready
- rN_rsp_result  out  DATA_W  ALU result
- rN_rsp_flags  out  4  {N,Z,C,V}
- rN_rsp_err  out  1  ctrl was illegal
- rN_rsp_tag  out  TAG_W  tag of the request

Behaviour:
- Reset (rst==0 at a clk edge): rN_rsp_valid=0, rN_rsp_result=0, flags=0, err=0, tag=0, rr_ptr=0 (requester 0 favoured). rN_ready is combinational, so it is also 0 during reset.
- Eligibility: requester N is eligible when rN_valid=1 and its slot can take data, i.e. rN_rsp_valid=0, or rN_rsp_ready=1 in the same cycle.
- Grant: at most one grant per cycle.
  - One eligible requester: it wins.
  - Both eligible: the requester pointed to by rr_ptr wins, and rr_ptr flips to the loser after the grant.
  - rr_ptr changes only on a cycle with contention.
- rN_ready = granted N. It never depends on rN_valid of the other requester except through arbitration. A requester blocked only by its own full slot does not block the other.
- Datapath: the granted operands and ctrl drive the single ALU combinationally. Result, flags, err and tag are registered into slot N at the same edge.
  - Latency is 1: accept at edge k, so rN_rsp_valid=1 after edge k.
  - Throughput is 1 op/cycle total.
- Slot update priority per edge:
  - granted: load, valid=1
  - else drained (valid & rsp_ready): valid=0
  - else hold
- Data outputs hold stable while rN_rsp_valid=1 and rsp_ready=0.
- Arithmetic (ALU semantics; width rules fixed here):
  - sum = A + (ctrl[0] ? ~B : B) + ctrl[0], computed at 33 bits; cout is bit 32.
  - slt result = {31'b0, sum[31]}, i.e. the raw sign of A-B with no overflow correction. This is intended and matches the existing core.
  - Z = (result == 0), full 32-bit compare.
  - N = result[31].
  - C = cout & ~ctrl[1].
  - V = ~ctrl[1] & (A[31]^sum[31]) & ~(A[31]^B[31]^ctrl[0]).
- Illegal ctrl: result=0, flags={0,1,C,V} as computed, err=1. The request is still accepted and returned, never dropped.
- Reset mid-operation: in-flight responses are discarded (valid=0). No partial state survives reset.
- Simultaneous grant and drain on the same slot: the new response overwrites, valid stays 1, and no bubble is inserted.

Decomposition:
- Shared package alu_pkg holds:
  - ctrl encodings: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101
  - flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - the legality function for ctrl
- Natural sub-module: existing ALU_8, instantiated once. Its Zero output is unused; Z is computed here as above.
- Response slot logic is written once and instantiated per requester; it is small, so a generate loop is acceptable in place of a separate module.

Test Plan:
- Single op: r0 add A=5, B=7, tag=3 → r0_ready=1 same cycle; next cycle r0_rsp_valid=1, result=12, flags=0000, tag=3, err=0.
- Contention: both valid every cycle with rsp_ready=1 from reset → grants go r0, r1, r0, r1. r0 sub 3-3 gives result 0, flags=0110. r1 or 0xF0|0x0F gives 0xFF, flags=0000.
- Backpressure: r0 issues twice with r0_rsp_ready=0 → first accepted, second stalls (r0_ready=0). r1 still granted each cycle. Raising r0_rsp_ready accepts the held request in the same cycle as the drain, with no bubble.
- Overflow/slt: add 0x7FFFFFFF+1 → 0x80000000, flags=1001. slt A=1, B=2 → result=1. slt A=0x80000000, B=1 → result=0 (raw sign of A-B, documented).
- Illegal op: r1 ctrl=3'b110, A=9, B=9 → result=0, err=1, Z=1, tag echoed.
- Reset mid-op: valid response held by rsp_ready=0, then rst=0 for 1 cycle → rsp_valid=0 and rr_ptr=0 after the edge; first contention after reset grants r0.
